// File: rtl/tl_arb_pkg.sv
// Shared TileLink-UL constants, widths and the A-channel beat payload for the two-master arbiter.
package tl_arb_pkg;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [2:0] TL_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [2:0]        param;
    logic [1:0]        size;
    logic [ADDR_W-1:0] address;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
  } a_beat_t;

endpackage

// File: rtl/tl_arb_a_slot.sv
// One-entry registered A-channel holding slot; refills in the same cycle it drains.
module tl_arb_a_slot
  import tl_arb_pkg::*;
#(
  parameter int unsigned SRC_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  a_beat_t          in_beat,
  input  logic [SRC_W-1:0] in_source,
  output logic             out_valid,
  input  logic             out_ready,
  output a_beat_t          out_beat,
  output logic [SRC_W-1:0] out_source
);

  logic             full;
  a_beat_t          beat_q;
  logic [SRC_W-1:0] source_q;

  assign in_ready   = !full || out_ready;
  assign out_valid  = full;
  assign out_beat   = beat_q;
  assign out_source = source_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      full <= 1'b0;
    end else if (in_ready) begin
      full <= in_valid;
    end
  end

  // Payload needs no reset: it is only observed while full is set.
  always_ff @(posedge clock) begin
    if (in_valid && in_ready) begin
      beat_q   <= in_beat;
      source_q <= in_source;
    end
  end

endmodule

// File: rtl/tl_ul_arb2.sv
// Two-master round-robin TileLink-UL arbiter with per-master outstanding limits and D routing.
// Define TL_ARB2_SRC_CHECK_EN to drop D beats for idle masters and expose the sticky src_err flag.
module tl_ul_arb2
  import tl_arb_pkg::*;
#(
  parameter int unsigned SRC_W   = 2,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              clock,
  input  logic              reset,
`ifdef TL_ARB2_SRC_CHECK_EN
  output logic              src_err,
`endif
  input  logic              m0_a_valid,
  output logic              m0_a_ready,
  input  logic [2:0]        m0_a_opcode,
  input  logic [2:0]        m0_a_param,
  input  logic [1:0]        m0_a_size,
  input  logic [SRC_W-1:0]  m0_a_source,
  input  logic [ADDR_W-1:0] m0_a_address,
  input  logic [MASK_W-1:0] m0_a_mask,
  input  logic [DATA_W-1:0] m0_a_data,
  output logic              m0_d_valid,
  input  logic              m0_d_ready,
  output logic [2:0]        m0_d_opcode,
  output logic [1:0]        m0_d_size,
  output logic [SRC_W-1:0]  m0_d_source,
  output logic [DATA_W-1:0] m0_d_data,
  output logic              m0_d_error,
  input  logic              m1_a_valid,
  output logic              m1_a_ready,
  input  logic [2:0]        m1_a_opcode,
  input  logic [2:0]        m1_a_param,
  input  logic [1:0]        m1_a_size,
  input  logic [SRC_W-1:0]  m1_a_source,
  input  logic [ADDR_W-1:0] m1_a_address,
  input  logic [MASK_W-1:0] m1_a_mask,
  input  logic [DATA_W-1:0] m1_a_data,
  output logic              m1_d_valid,
  input  logic              m1_d_ready,
  output logic [2:0]        m1_d_opcode,
  output logic [1:0]        m1_d_size,
  output logic [SRC_W-1:0]  m1_d_source,
  output logic [DATA_W-1:0] m1_d_data,
  output logic              m1_d_error,
  output logic              s_a_valid,
  input  logic              s_a_ready,
  output logic [2:0]        s_a_opcode,
  output logic [2:0]        s_a_param,
  output logic [1:0]        s_a_size,
  output logic [SRC_W:0]    s_a_source,
  output logic [ADDR_W-1:0] s_a_address,
  output logic [MASK_W-1:0] s_a_mask,
  output logic [DATA_W-1:0] s_a_data,
  input  logic              s_d_valid,
  output logic              s_d_ready,
  input  logic [2:0]        s_d_opcode,
  input  logic [1:0]        s_d_size,
  input  logic [SRC_W:0]    s_d_source,
  input  logic [DATA_W-1:0] s_d_data,
  input  logic              s_d_error
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  logic [1:0][CNT_W-1:0] cnt;
  logic [1:0]            elig;
  logic [1:0]            a_fire;
  logic [1:0]            d_fire;
  logic                  rr_last;
  logic                  grant_id;
  logic                  slot_in_valid;
  logic                  slot_in_ready;
  a_beat_t               m0_beat;
  a_beat_t               m1_beat;
  a_beat_t               slot_in_beat;
  logic [SRC_W:0]        slot_in_source;
  a_beat_t               slot_out_beat;
  logic                  d_sel;
  logic                  d_drop;

  assign m0_beat = '{opcode: m0_a_opcode, param: m0_a_param, size: m0_a_size,
                     address: m0_a_address, mask: m0_a_mask, data: m0_a_data};
  assign m1_beat = '{opcode: m1_a_opcode, param: m1_a_param, size: m1_a_size,
                     address: m1_a_address, mask: m1_a_mask, data: m1_a_data};

  // Round-robin grant among masters that are valid and below their outstanding limit.
  always_comb begin
    elig[0]        = m0_a_valid && (cnt[0] < CNT_MAX);
    elig[1]        = m1_a_valid && (cnt[1] < CNT_MAX);
    grant_id       = 1'b0;
    if (elig[0] && elig[1]) begin
      grant_id = ~rr_last;
    end else if (elig[1]) begin
      grant_id = 1'b1;
    end
    slot_in_valid  = reset && (|elig);
    a_fire[0]      = slot_in_valid && slot_in_ready && !grant_id;
    a_fire[1]      = slot_in_valid && slot_in_ready && grant_id;
    slot_in_beat   = grant_id ? m1_beat : m0_beat;
    slot_in_source = {grant_id, grant_id ? m1_a_source : m0_a_source};
  end

  assign m0_a_ready = a_fire[0];
  assign m1_a_ready = a_fire[1];

  tl_arb_a_slot #(
    .SRC_W(SRC_W + 1)
  ) u_a_slot (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (slot_in_valid),
    .in_ready   (slot_in_ready),
    .in_beat    (slot_in_beat),
    .in_source  (slot_in_source),
    .out_valid  (s_a_valid),
    .out_ready  (s_a_ready),
    .out_beat   (slot_out_beat),
    .out_source (s_a_source)
  );

  assign s_a_opcode  = slot_out_beat.opcode;
  assign s_a_param   = slot_out_beat.param;
  assign s_a_size    = slot_out_beat.size;
  assign s_a_address = slot_out_beat.address;
  assign s_a_mask    = slot_out_beat.mask;
  assign s_a_data    = slot_out_beat.data;

  // D routing keyed on the master bit prepended to the source on the A side.
  assign d_sel = s_d_source[SRC_W];

`ifdef TL_ARB2_SRC_CHECK_EN
  assign d_drop = (cnt[d_sel] == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      src_err <= 1'b0;
    end else if (s_d_valid && d_drop) begin
      src_err <= 1'b1;
    end
  end
`else
  assign d_drop = 1'b0;
`endif

  assign s_d_ready  = d_drop || (d_sel ? m1_d_ready : m0_d_ready);
  assign m0_d_valid = s_d_valid && !d_sel && !d_drop;
  assign m1_d_valid = s_d_valid && d_sel && !d_drop;
  assign d_fire[0]  = m0_d_valid && m0_d_ready;
  assign d_fire[1]  = m1_d_valid && m1_d_ready;

  assign m0_d_opcode = s_d_opcode;
  assign m0_d_size   = s_d_size;
  assign m0_d_source = s_d_source[SRC_W-1:0];
  assign m0_d_data   = s_d_data;
  assign m0_d_error  = s_d_error;
  assign m1_d_opcode = s_d_opcode;
  assign m1_d_size   = s_d_size;
  assign m1_d_source = s_d_source[SRC_W-1:0];
  assign m1_d_data   = s_d_data;
  assign m1_d_error  = s_d_error;

  // Outstanding counters saturate at zero; rr_last starts at 1 so master 0 wins the first tie.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt     <= '0;
      rr_last <= 1'b1;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (a_fire[n] && !d_fire[n]) begin
          cnt[n] <= cnt[n] + CNT_W'(1);
        end else if (d_fire[n] && !a_fire[n] && (cnt[n] != '0)) begin
          cnt[n] <= cnt[n] - CNT_W'(1);
        end
      end
      if (|a_fire) begin
        rr_last <= grant_id;
      end
    end
  end

endmodule

// File: doc/tl_ul_arb2.md
Name: tl_ul_arb2

Overview:
- Two-requester arbiter for a 32-bit TileLink-UL port.
- Shares one downstream slave port between master 0 and master 1 using round-robin on the A channel.
- The A channel passes through a one-entry registered slot.
- D responses route back to the issuing master using a source-ID bit the block prepends.
- Sits between core-side ports (fetch/LSU or debug) and a single peripheral or memory crossbar input.

Parameters:
- SRC_W, 2, width of each master's a_source/d_source.
- MAX_OUT, 4, maximum outstanding A requests per master (1..15).

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous active-low reset.
- mN_a_valid  in  1  master N (N=0,1) request valid.
- mN_a_ready  out  1  master N request accepted.
- mN_a_opcode  in  3  A opcode.
- mN_a_param  in  3  A param.
- mN_a_size  in  2  log2 bytes.
- mN_a_source  in  SRC_W  master transaction ID.
- mN_a_address  in  30  address.
- mN_a_mask  in  4  byte mask.
- mN_a_data  in  32  write data.
- mN_d_valid  out  1  response valid to master N.
- mN_d_ready  in  1  master N accepts response.
- mN_d_opcode  out  3  D opcode.
- mN_d_size  out  2  D size.
- mN_d_source  out  SRC_W  d_source with the master bit stripped.
- mN_d_data  out  32  read data.
- mN_d_error  out  1  denied/corrupt.
- s_a_valid/s_a_ready  out/in  1  downstream A handshake.
- s_a_opcode, s_a_param, s_a_size, s_a_address, s_a_mask, s_a_data  out  3,3,2,30,4,32  registered A fields.
- s_a_source  out  SRC_W+1  {grant_id, mN_a_source}.
- s_d_valid/s_d_ready  in/out  1  downstream D handshake.
- s_d_opcode, s_d_size, s_d_source, s_d_data, s_d_error  in  3,2,SRC_W+1,32,1  D fields.
- src_err  out  1  sticky error flag; present only with the optional feature.

Behaviour:
- Reset:
  - slot empty; s_a_valid=0.
  - Both outstanding counters = 0.
  - rr_last = 1, so master 0 wins the first tie.
  - src_err = 0.
  - All mN_a_ready = 0 during reset.
- Eligibility: master N is eligible when mN_a_valid=1 and cnt_N < MAX_OUT.
  - A counter at MAX_OUT blocks its master even if a D retire occurs that cycle.
- Slot load condition: the slot loads when it is empty, or when it is full and s_a_ready=1 (drain and refill in the same cycle give full throughput).
- Grant:
  - When the slot can load, grant goes to the eligible master not equal to rr_last.
  - If only one master is eligible, it is granted.
  - mN_a_ready=1 only for the granted master; the grant is combinational.
  - rr_last updates to the granted ID on the fire.
- Latency: A fire at cycle t makes s_a_valid=1 with captured fields at t+1.
- Slot stability: while s_a_valid=1 and s_a_ready=0, the slot holds and all s_a fields stay stable.
- D routing:
  - Master select bit is the MSB of s_d_source.
  - The selected mN_d_valid = s_d_valid; all fields pass combinationally.
  - s_d_ready = mSEL_d_ready.
  - The non-selected master's d_valid = 0.
- Counters:
  - cnt_N +1 on master N A fire.
  - cnt_N −1 on master N D fire.
  - Both in the same cycle leave the count unchanged.
  - 4-bit width; a decrement never wraps below 0.
- A and D are independent: a D retire and an A grant may occur in the same cycle.
- Mid-operation reset: the in-flight slot is discarded and counters are cleared. The downstream slave must be reset together with this block.

Optional Feature:
- Macro: TL_ARB2_SRC_CHECK_EN.
- With the macro:
  - A D beat whose target master has cnt_N=0 is dropped: s_d_ready=1, mN_d_valid=0.
  - src_err sets and holds until reset.
- Without the macro:
  - Such a beat is forwarded normally and the counter stays at 0.
  - The src_err port is absent.

Decomposition:
- Package tl_arb_pkg holds:
  - TL opcode constants: Get=4, PutFull=0, PutPartial=1, AccessAck=0, AccessAckData=1.
  - Fixed widths: ADDR_W=30, DATA_W=32.
  - An A-beat struct typedef.
- Sub-module tl_arb_a_slot: the one-entry registered A holding slot, with in_valid/in_ready/out_valid/out_ready.

Test Plan:
- Both masters are valid continuously and s_a_ready=1 → s_a_source MSB alternates 0,1,0,1 with one beat per cycle after the first.
- Only m1 is valid with address 0x0000_0100 → s_a_valid=1 next cycle, s_a_source={1,m1_source}, s_a_address=0x100.
- s_a_ready held at 0 for 3 cycles with a slot full → s_a fields stable, both mN_a_ready=0; release → slot drains and refills in the same cycle.
- m0 issues 4 Gets with no responses (MAX_OUT=4) → fifth request blocked (m0_a_ready=0) while m1 is still granted; one D to m0 → m0 eligible the next cycle.
- s_d_source=3'b1_01 with data 0xDEADBEEF → m1_d_valid=1, m1_d_source=2'b01, m0_d_valid=0; m1_d_ready=0 → s_d_ready=0.
- With TL_ARB2_SRC_CHECK_EN: D to m0 while cnt_0=0 → m0_d_valid=0, s_d_ready=1, src_err=1 held until reset.
